// File: rtl/alu_iter.sv
// ============================================================================
// alu_iter -- multi-cycle execute-stage ALU with valid/ready handshakes.
//
// Accepts one operation at a time. Single-cycle operations (add, sub, logic,
// shifts, compares) complete at the accept edge. The iterative multiply and
// divide operations step once per clock. The result is held until the
// consumer takes it.
//
// Optional feature macro: ALU_MULDIV_EN
//   defined   -> sel 1100..1111 (mul, mulhu, divu, remu) run iteratively,
//                taking N steps in the BUSY state
//   undefined -> those codes are unsupported (result 0, zero 1, one cycle),
//                and the BUSY datapath and counter are not built
//
// Parameters:
//   N    operand/result width (>= 8, power of two)
//   SHW  shift-amount width, taken from B[SHW-1:0]
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands/op presented
//   in_ready   block can accept an operation (IDLE)
//   A, B       operands
//   sel        operation select
//   out_valid  result/zero valid (DONE)
//   out_ready  consumer takes result
//   result     registered result
//   zero       registered (result == 0)
//   busy       operation in flight (BUSY or DONE)
// ============================================================================
module alu_iter #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic         zero_q;
    logic [N-1:0] result_q;

    logic [N-1:0] single_res;
    logic         accept;
    logic         is_iter;

    // Combinational result of every single-cycle op; unknown codes give 0.
    function automatic logic [N-1:0] alu_single(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic [3:0]   op
    );
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sb;
        logic [SHW-1:0]      sh;
        logic [N-1:0]        r;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        r  = '0;
        case (op)
            4'b0010: r = a + b;
            4'b0110: r = a + ~b + N'(1);
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b0100: r = a << sh;
            4'b0101: r = a >> sh;
            4'b0111: r = sa >>> sh;
            4'b1000: r = {{(N-1){1'b0}}, (sa < sb)};
            4'b1001: r = {{(N-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    assign accept     = (state_q == S_IDLE) && in_valid;
    assign single_res = alu_single(A, B, sel);

`ifdef ALU_MULDIV_EN
    localparam int CW = $clog2(N) + 1;

    logic [CW-1:0] cnt_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [1:0]    op_q;      // [1]: 0 = multiply, 1 = divide; [0]: take high half
    logic [N-1:0]  hi_q;      // mul: partial-product high half; div: remainder
    logic [N-1:0]  lo_q;      // mul: multiplier/low product;   div: quotient
    logic [N-1:0]  hi_d;
    logic [N-1:0]  lo_d;
    logic [N:0]    sum;
    logic [N:0]    rem_sh;
    logic [N-1:0]  iter_res;

    assign is_iter = (sel[3:2] == 2'b11);

    // One iteration step. Multiply: conditionally add A to the high half,
    // then shift the {carry, hi, lo} pair right. Divide: shift the next
    // dividend bit into the remainder and subtract B when it fits. A zero
    // divisor always "fits", yielding an all-ones quotient and remainder A.
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        rem_sh = {hi_q, lo_q[N-1]};
        if (!op_q[1]) begin
            hi_d = sum[N:1];
            lo_d = {sum[0], lo_q[N-1:1]};
        end else if (rem_sh >= {1'b0, b_q}) begin
            hi_d = N'(rem_sh - {1'b0, b_q});
            lo_d = {lo_q[N-2:0], 1'b1};
        end else begin
            hi_d = rem_sh[N-1:0];
            lo_d = {lo_q[N-2:0], 1'b0};
        end
    end

    // Result taken from the final step's next values so DONE follows the
    // last step directly.
    assign iter_res = op_q[0] ? hi_d : lo_d;

    always_ff @(posedge clk) begin
        if (accept && is_iter) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= sel[1:0];
            hi_q <= '0;
            lo_q <= sel[1] ? A : B;
        end else if (state_q == S_BUSY) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
`else
    assign is_iter = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef ALU_MULDIV_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (is_iter) begin
                            state_q <= S_BUSY;
`ifdef ALU_MULDIV_EN
                            cnt_q   <= CW'(N);
`endif
                        end else begin
                            result_q    <= single_res;
                            zero_q      <= (single_res == '0);
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
`ifdef ALU_MULDIV_EN
                S_BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q    <= iter_res;
                        zero_q      <= (iter_res == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter (N = 32). The driver pushes the expected
// result, zero flag, latency and accept cycle for every accepted operation;
// the monitor compares on every cycle the DUT presents out_valid and pops on
// the handshake. Expected values come from plain-arithmetic rules; the
// mul/div expectations follow ALU_MULDIV_EN exactly as the design does.
module tb_alu_iter;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [3:0]   sel = '0;
    logic         in_ready;
    logic         out_valid;
    logic         zero;
    logic         busy;
    logic [N-1:0] result;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0: out_ready low, 1: random, 2: high
    logic prev_valid = 1'b0;

    typedef struct {
        logic [N-1:0] r;
        logic         z;
        int           lat;
        int           acc;
    } exp_t;
    exp_t q[$];

    alu_iter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference rules for each sel code.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] s, output logic [31:0] r,
                                  output int lat);
        longint unsigned p;
        int sh;
        sh  = int'(b % 32);
        lat = 1;
        r   = 32'd0;
        p   = {32'd0, a} * {32'd0, b};
        case (s)
            4'd2:  r = a + b;
            4'd6:  r = a - b;
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd3:  r = a ^ b;
            4'd4:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd7:  begin
                       r = a >> sh;
                       if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                   end
            4'd8:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
            4'd12: begin r = p[31:0];  lat = N + 1; end
            4'd13: begin r = p[63:32]; lat = N + 1; end
            4'd14: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = N + 1; end
            4'd15: begin r = (b == 0) ? a : a % b;            lat = N + 1; end
`endif
            default: r = 32'd0;
        endcase
    endfunction

    // Monitor: checks every presented output against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output actual=%0h required=no output", result);
            end else begin
                if (!prev_valid) chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
                chk("result", 64'(result), 64'(q[0].r));
                chk("zero", 64'(zero), 64'(q[0].z));
                chk("in_ready_low_when_done", 64'(in_ready), 64'd0);
                chk("busy_high_when_done", 64'(busy), 64'd1);
                if (out_ready) void'(q.pop_front());
            end
        end
        prev_valid <= rst_n && out_valid;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        int w;
        logic [31:0] r;
        int lat;
        w = 0;
        while (!in_ready && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end else begin
            A = a; B = b; sel = s; in_valid = 1'b1;
            model(a, b, s, r, lat);
            q.push_back('{r, (r == 32'd0), lat, cyc + 1});
            @(posedge clk); #1;
            in_valid = 1'b0;
            // Operands may change after acceptance without effect.
            A = $urandom; B = $urandom; sel = 4'($urandom);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
            q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] e [4];
        e[0] = 32'h0; e[1] = 32'hFFFF_FFFF; e[2] = 32'h8000_0000; e[3] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 300));
            1:       return e[$urandom_range(0, 3)];
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] dA [12] = '{32'd9, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h0000_FFFF, 32'd100, 32'd100, 32'd100, 32'd100, 32'd3, 32'd77};
    logic [31:0] dB [12] = '{32'd9, 32'd1, 32'h24, 32'd1, 32'd1,
                             32'h0001_0001, 32'd7, 32'd7, 32'd0, 32'd0, 32'd4, 32'd5};
    logic [3:0]  dS [12] = '{4'b0110, 4'b0110, 4'b0111, 4'b1000, 4'b1001,
                             4'b1100, 4'b1110, 4'b1111, 4'b1110, 4'b1111, 4'b1100, 4'b1010};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_zero", 64'(zero), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // Add, then hold the result for several cycles with out_ready low.
        rdy_mode = 0;
        issue(32'd5, 32'd7, 4'b0010);
        repeat (4) @(posedge clk);
        #1;
        rdy_mode = 2;
        drain();

        // Directed table.
        rdy_mode = 1;
        for (int i = 0; i < 12; i++) issue(dA[i], dB[i], dS[i]);
        drain();

        // Reset in the middle of an operation.
        rdy_mode = 0;
        issue(32'd100, 32'd7, 4'b1110);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_result", 64'(result), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_result", 64'(out_valid), 64'd0);

        // in_valid toggling while an operation is in flight is ignored.
        issue(32'd100, 32'd7, 4'b1110);
        for (int i = 0; i < 6; i++) begin
            A = 32'd1; B = 32'd1; sel = 4'b0010; in_valid = ~in_valid;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rdy_mode = 2;
        drain();
        rdy_mode = 0;
        chk("ignore_out_valid", 64'(out_valid), 64'd0);
        chk("ignore_busy", 64'(busy), 64'd0);
        chk("ignore_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("ignore_no_extra", 64'(out_valid), 64'd0);

        // Randomized operations.
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            issue(pick(), pick(), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
